// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC and sequences the 3-cycle relative-branch
// path (offset prepare, then add) alongside single-cycle INC/JMP/HOLD updates.
module pc_sequencer #(
    parameter int              PC_W     = 16,
    parameter int              IMM_W    = 12,
    parameter int              INC      = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       op,
    input  logic             cond,
    input  logic [IMM_W-1:0] imm,
    input  logic [PC_W-1:0]  target,
    input  logic             flush,
    output logic [PC_W-1:0]  pc,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OFFSET = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_BR   = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   off_q, off_d;
    logic              done_q, done_d;
    logic              accept;
    logic [PC_W-1:0]   br_off;

    // Handshake: a request transfers on a clock edge where req_valid && req_ready;
    // op/cond/imm/target are sampled only on that edge. The requester holds the
    // request until then; req_valid while busy has no effect.
    assign req_ready = (state_q == S_IDLE) && !flush && rst_n;
    assign accept    = req_valid && req_ready;

    // Halfword immediate becomes a byte offset, sign-extended to the PC width.
    assign br_off = {{(PC_W-IMM_W-1){imm[IMM_W-1]}}, imm, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            off_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            off_q   <= off_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        off_d   = off_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_INC: begin
                            pc_d   = pc_q + INC_V;
                            done_d = 1'b1;
                        end
                        OP_BR: begin
                            if (cond) begin
                                off_d   = br_off;
                                state_d = S_OFFSET;
                            end else begin
                                pc_d   = pc_q + INC_V;
                                done_d = 1'b1;
                            end
                        end
                        OP_JMP: begin
                            pc_d   = {target[PC_W-1:1], 1'b0};
                            done_d = 1'b1;
                        end
                        OP_HOLD: begin
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_OFFSET: begin
                state_d = flush ? S_IDLE : S_UPDATE;
            end
            S_UPDATE: begin
                // Flush wins over the write: the branch retires nothing.
                state_d = S_IDLE;
                if (!flush) begin
                    pc_d   = pc_q + off_q;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc        = pc_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed requests push expected PCs into a queue and a
// negedge monitor pops one per done pulse.
module tb_pc_sequencer;

    localparam int PC_W  = 16;
    localparam int IMM_W = 12;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       op;
    logic             cond;
    logic [IMM_W-1:0] imm;
    logic [PC_W-1:0]  target;
    logic             flush;
    logic [PC_W-1:0]  pc;
    logic             done;
    logic             busy;
    logic [1:0]       state_dbg;

    logic [PC_W-1:0]  exp_q[$];
    int               pass_cnt;
    int               total_cnt;
    int               done_cnt;
    int               push_cnt;

    pc_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .cond      (cond),
        .imm       (imm),
        .target    (target),
        .flush     (flush),
        .pc        (pc),
        .done      (done),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Driver: waits (bounded) for req_ready, presents one request for one edge.
    task automatic issue(input logic [1:0] o, input logic c, input logic [IMM_W-1:0] im,
                         input logic [PC_W-1:0] tg, input bit has_exp, input logic [PC_W-1:0] exp_pc);
        int waited;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            check("issue_ready_timeout", {31'd0, req_ready}, 32'd1);
            return;
        end
        req_valid = 1'b1;
        op        = o;
        cond      = c;
        imm       = im;
        target    = tg;
        if (has_exp) begin
            exp_q.push_back(exp_pc);
            push_cnt++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    logic [PC_W-1:0] e;
                    e = exp_q.pop_front();
                    check("retired_pc", {16'd0, pc}, {16'd0, e});
                end
            end
        end
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        done_cnt  = 0;
        push_cnt  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        op        = 2'b00;
        cond      = 1'b0;
        imm       = '0;
        target    = '0;
        flush     = 1'b0;

        #2;
        check("reset_pc",    {16'd0, pc}, 32'h0000);
        check("reset_done",  {31'd0, done}, 32'd0);
        check("reset_busy",  {31'd0, busy}, 32'd0);
        check("reset_ready", {31'd0, req_ready}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("ready_after_release", {31'd0, req_ready}, 32'd1);

        // INC x3 back-to-back
        issue(2'b00, 1'b0, '0, '0, 1'b1, 16'h0002);
        check("inc_ready_1", {31'd0, req_ready}, 32'd1);
        issue(2'b00, 1'b0, '0, '0, 1'b1, 16'h0004);
        check("inc_ready_2", {31'd0, req_ready}, 32'd1);
        issue(2'b00, 1'b0, '0, '0, 1'b1, 16'h0006);
        check("inc_pc_3", {16'd0, pc}, 32'h0006);

        // Backward branch
        issue(2'b10, 1'b0, '0, 16'h0100, 1'b1, 16'h0100);
        issue(2'b01, 1'b1, 12'hFFE, '0, 1'b1, 16'h00FC);
        check("br_offset_busy",  {31'd0, busy}, 32'd1);
        check("br_offset_ready", {31'd0, req_ready}, 32'd0);
        check("br_offset_pc",    {16'd0, pc}, 32'h0100);
        step();
        check("br_update_busy",  {31'd0, busy}, 32'd1);
        check("br_update_ready", {31'd0, req_ready}, 32'd0);
        check("br_update_state", {30'd0, state_dbg}, 32'd2);
        step();
        check("br_back_pc",   {16'd0, pc}, 32'h00FC);
        check("br_back_idle", {31'd0, busy}, 32'd0);

        // Forward branch with wrap, then not-taken branch
        issue(2'b10, 1'b0, '0, 16'hF100, 1'b1, 16'hF100);
        issue(2'b01, 1'b1, 12'h7FF, '0, 1'b1, 16'h00FE);
        step();
        step();
        issue(2'b01, 1'b0, 12'h7FF, '0, 1'b1, 16'h0100);
        check("br_nt_pc", {16'd0, pc}, 32'h0100);

        // JMP alignment, HOLD
        issue(2'b10, 1'b0, '0, 16'h1235, 1'b1, 16'h1234);
        issue(2'b11, 1'b0, '0, 16'hFFFF, 1'b1, 16'h1234);

        // Flush in OFFSET
        issue(2'b10, 1'b0, '0, 16'h0200, 1'b1, 16'h0200);
        issue(2'b01, 1'b1, 12'h010, '0, 1'b0, '0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_off_busy",  {31'd0, busy}, 32'd0);
        check("flush_off_state", {30'd0, state_dbg}, 32'd0);
        check("flush_off_pc",    {16'd0, pc}, 32'h0200);
        step();
        step();

        // Flush in UPDATE; flush while idle blocks acceptance
        issue(2'b01, 1'b1, 12'h010, '0, 1'b0, '0);
        step();
        flush = 1'b1;
        step();
        check("flush_upd_busy",   {31'd0, busy}, 32'd0);
        check("flush_upd_pc",     {16'd0, pc}, 32'h0200);
        check("flush_idle_ready", {31'd0, req_ready}, 32'd0);
        flush = 1'b0;
        #1;
        check("unflush_ready", {31'd0, req_ready}, 32'd1);
        step();
        step();

        // Async reset during UPDATE
        issue(2'b01, 1'b1, 12'h010, '0, 1'b0, '0);
        step();
        check("pre_reset_state", {30'd0, state_dbg}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc",    {16'd0, pc}, 32'h0000);
        check("async_rst_busy",  {31'd0, busy}, 32'd0);
        check("async_rst_done",  {31'd0, done}, 32'd0);
        check("async_rst_ready", {31'd0, req_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        issue(2'b00, 1'b0, '0, '0, 1'b1, 16'h0002);
        check("post_rst_pc", {16'd0, pc}, 32'h0002);

        // Drain
        repeat (4) step();
        check("queue_empty", exp_q.size(), 32'd0);
        check("done_count",  done_cnt, push_cnt);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
